// File: rtl/spi_xfer_sched_pkg.sv
// Shared types and helpers for the SPI transfer scheduler.
package spi_xfer_pkg;

  // Scheduler sequence: arbitrate, select slave, clock bits, hold select.
  typedef enum logic [2:0] {
    IDLE,
    ARB,
    SETUP,
    RUN,
    HOLD
  } xfer_state_e;

  // Width of the slave-select setup/hold counter (CS_CYC up to 256).
  localparam int unsigned CS_CNT_W = 8;

  // Index width for an n-entry vector; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of slice k in a vector of w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/spi_xfer_sched_if.sv
// Link between the transfer scheduler and the SPI clock generator.
interface spi_xfer_sched_if #(
  parameter int unsigned DIV_LEN = 16
);

  logic               clg_enable_o;
  logic               clg_go_o;
  logic               clg_last_o;
  logic [DIV_LEN-1:0] clg_div_o;
  logic               clg_pos_i;
  logic               clg_neg_i;

  // Scheduler side.
  modport master (
    output clg_enable_o,
    output clg_go_o,
    output clg_last_o,
    output clg_div_o,
    input  clg_pos_i,
    input  clg_neg_i
  );

  // Clock generator side.
  modport slave (
    input  clg_enable_o,
    input  clg_go_o,
    input  clg_last_o,
    input  clg_div_o,
    output clg_pos_i,
    output clg_neg_i
  );

endinterface

// File: rtl/spi_xfer_sched_arb.sv
// Round-robin request arbiter: first set request at or after the pointer,
// wrapping. Purely combinational.
module spi_rr_arbiter
  import spi_xfer_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]            i_req,
  input  logic [idx_width(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]            o_gnt,
  output logic [idx_width(NREQ)-1:0] o_idx
);

  localparam int unsigned IDX_W = idx_width(NREQ);

  logic              w_found;
  int unsigned       w_k;
  logic [IDX_W-1:0]  w_ki;

  // Scan requesters starting at the pointer; keep the first hit.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    w_ki    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_k = 32'(i_ptr) + i;
      if (w_k >= NREQ) w_k = w_k - NREQ;
      w_ki = IDX_W'(w_k);
      if (!w_found && i_req[w_ki]) begin
        w_found     = 1'b1;
        o_gnt[w_ki] = 1'b1;
        o_idx       = w_ki;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_sched.sv
// SPI transfer scheduler: shares one clock generator/shifter between NREQ
// requesters with round-robin arbitration, slave-select setup/hold timing
// and bit counting from the generator's edge pulses.
// Optional watchdog on the clocking phase: define SPI_XFER_TMO_EN.
module spi_xfer_sched
  import spi_xfer_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DIV_LEN = 16,
  parameter int unsigned CNT_LEN = 7,
  parameter int unsigned CS_CYC  = 2,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*DIV_LEN-1:0] div_i,
  input  logic [NREQ*CNT_LEN-1:0] len_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic [NREQ-1:0]         err_o,
  output logic [NREQ-1:0]         ss_n_o,
  output logic                    tip_o,
  spi_xfer_sched_if.master        clg
);

  localparam int unsigned          IDX_W   = idx_width(NREQ);
  localparam int unsigned          BIT_W   = CNT_LEN + 1;
  localparam logic [CS_CNT_W-1:0]  CS_LAST = CS_CNT_W'(CS_CYC - 1);
  localparam logic [IDX_W-1:0]     IDX_MAX = IDX_W'(NREQ - 1);

  if (NREQ < 2 || CS_CYC < 1 || CS_CYC > (1 << CS_CNT_W) || TMO_CYC < 1) begin : g_bad_cfg
    $error("spi_xfer_sched: invalid parameter set");
  end

  xfer_state_e         r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [NREQ-1:0]     r_gnt;
  logic [NREQ-1:0]     r_done;
  logic [NREQ-1:0]     r_ss_n;
  logic                r_tip;
  logic                r_en;
  logic                r_go;
  logic                r_last;
  logic [DIV_LEN-1:0]  r_div_lat;
  logic [DIV_LEN-1:0]  r_clg_div;
  logic [BIT_W-1:0]    r_bits;
  logic [CS_CNT_W-1:0] r_cs;

  logic [NREQ-1:0]     w_gnt;
  logic [IDX_W-1:0]    w_idx;
  logic [DIV_LEN-1:0]  w_div_sel;
  logic [CNT_LEN-1:0]  w_len_sel;
  logic [BIT_W-1:0]    w_len_bits;
  logic [BIT_W-1:0]    w_bits_nxt;
  logic                w_run_done;
  logic                w_tmo_hit;
  logic                w_run_exit;

`ifdef SPI_XFER_TMO_EN
  localparam int unsigned      TMO_W    = idx_width(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] r_tmo;
  logic             r_tmo_flag;
  logic [NREQ-1:0]  r_err;

  // Watchdog expires on the TMO_CYC-th RUN cycle unless the transfer ends then.
  assign w_tmo_hit = (r_tmo == TMO_LAST) && !w_run_done;
  assign err_o     = r_err;
`else
  assign w_tmo_hit = 1'b0;
  assign err_o     = '0;
`endif

  spi_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  // Select the winner's divider and length slices.
  always_comb begin
    w_div_sel = '0;
    w_len_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_idx == IDX_W'(k)) begin
        w_div_sel = div_i[slice_lo(k, DIV_LEN) +: DIV_LEN];
        w_len_sel = len_i[slice_lo(k, CNT_LEN) +: CNT_LEN];
      end
    end
  end

  // Zero length encodes the full 2**CNT_LEN bits.
  assign w_len_bits = (w_len_sel == '0) ? {1'b1, {CNT_LEN{1'b0}}} : {1'b0, w_len_sel};

  // Bit count after this cycle's pos edge; exit is judged on the new count
  // so simultaneous pos/neg pulses finish on the last bit.
  always_comb begin
    w_bits_nxt = r_bits;
    if (clg.clg_pos_i && (r_bits != '0)) w_bits_nxt = r_bits - 1'b1;
  end

  assign w_run_done = clg.clg_neg_i && (w_bits_nxt == '0);
  assign w_run_exit = w_run_done || w_tmo_hit;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_ss_n    <= '1;
      r_tip     <= 1'b0;
      r_en      <= 1'b0;
      r_go      <= 1'b0;
      r_last    <= 1'b0;
      r_div_lat <= '0;
      r_clg_div <= '1;
      r_bits    <= '0;
      r_cs      <= '0;
`ifdef SPI_XFER_TMO_EN
      r_tmo      <= '0;
      r_tmo_flag <= 1'b0;
      r_err      <= '0;
`endif
    end else begin
      r_go   <= 1'b0;
      r_done <= '0;
`ifdef SPI_XFER_TMO_EN
      r_err  <= '0;
`endif
      case (r_state)
        // Arbitration is resolved on the way into ARB so the grant is
        // already visible during the ARB cycle.
        IDLE: begin
          if (|req_i) begin
            r_state   <= ARB;
            r_gnt     <= w_gnt;
            r_div_lat <= w_div_sel;
            r_bits    <= w_len_bits;
            r_ptr     <= (w_idx == IDX_MAX) ? '0 : w_idx + 1'b1;
          end
        end
        ARB: begin
          r_state   <= SETUP;
          r_ss_n    <= ~r_gnt;
          r_tip     <= 1'b1;
          r_clg_div <= r_div_lat;
          r_cs      <= '0;
          if (CS_CYC == 1) r_go <= 1'b1;
        end
        SETUP: begin
          if (r_cs == CS_LAST) begin
            r_state <= RUN;
            r_en    <= 1'b1;
            r_last  <= (r_bits <= BIT_W'(1));
`ifdef SPI_XFER_TMO_EN
            r_tmo   <= '0;
`endif
          end else begin
            r_cs <= r_cs + 1'b1;
            if (r_cs + 1'b1 == CS_LAST) r_go <= 1'b1;
          end
        end
        RUN: begin
          r_bits <= w_bits_nxt;
          r_last <= (w_bits_nxt <= BIT_W'(1));
`ifdef SPI_XFER_TMO_EN
          r_tmo  <= r_tmo + 1'b1;
`endif
          if (w_run_exit) begin
            r_state <= HOLD;
            r_en    <= 1'b0;
            r_last  <= 1'b0;
            r_cs    <= '0;
`ifdef SPI_XFER_TMO_EN
            r_tmo_flag <= w_tmo_hit;
`endif
            if (CS_CYC == 1) begin
              r_done <= r_gnt;
`ifdef SPI_XFER_TMO_EN
              r_err  <= w_tmo_hit ? r_gnt : '0;
`endif
            end
          end
        end
        HOLD: begin
          if (r_cs == CS_LAST) begin
            r_state <= IDLE;
            r_ss_n  <= '1;
            r_gnt   <= '0;
            r_tip   <= 1'b0;
          end else begin
            r_cs <= r_cs + 1'b1;
            if (r_cs + 1'b1 == CS_LAST) begin
              r_done <= r_gnt;
`ifdef SPI_XFER_TMO_EN
              r_err  <= r_tmo_flag ? r_gnt : '0;
`endif
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_o            = r_gnt;
  assign done_o           = r_done;
  assign ss_n_o           = r_ss_n;
  assign tip_o            = r_tip;
  assign clg.clg_enable_o = r_en;
  assign clg.clg_go_o     = r_go;
  assign clg.clg_last_o   = r_last;
  assign clg.clg_div_o    = r_clg_div;

endmodule
